oled_frame_sched: RTL
=====================

# oled_frame_sched

Sequencer that owns the OLED panel's serial byte writer and decides what it sends. After reset it drives the panel reset pin, then streams the fixed init command table. From then on it sends a window-set command block plus one full 64×192-byte frame from the pixel ROM whenever the displayed track index changes or a refresh is forced. It sits between the player control logic (track index) and the SPI byte serializer / pixel ROM.

## Interface
- RES_CYCLES, 20000: CLK cycles RES is held low after reset release.
- WAIT_CYCLES, 20000: CLK cycles waited after RES rises before the first init byte.
- ROWS, 64: rows per frame.
- ROW_BYTES, 192: bytes per row.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- current  in  3  track index selecting the ROM image.
- force_refresh  in  1  one-cycle pulse that requests a redraw.
- tx_ready  in  1  serializer can accept a byte.
- tx_valid  out  1  byte offered to the serializer.
- tx_byte  out  8  byte to shift.
- tx_dc  out  1  0 = command, 1 = data.
- pix_addr  out  17  ROM address {shown, row[5:0], col[7:0]}.
- pix_data  in  8  ROM data, valid 1 cycle after pix_addr.
- RES  out  1  panel reset pin, active low.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel byte is accepted.

## Operation
- Reset values: RES=0, tx_valid=0, tx_byte=0, tx_dc=0, pix_addr=0, busy=1, frame_done=0, shown=0, pending=0; state=RST_HOLD.
- RST_HOLD: count RES_CYCLES, then set RES=1 and go to RST_WAIT.
- RST_WAIT: count WAIT_CYCLES, then go to INIT with idx=0.
- INIT: send 37 command bytes (tx_dc=0) in this order: AE A0 76 A1 00 A2 00 A4 A8 3F AD 8E B0 0B B1 31 B3 F0 8A 64 8B 78 8C 64 BB 3A BE 3E 87 06 81 91 82 50 83 7D AF.
  - After byte 36 is accepted: latch shown←current, clear pending, go to WIN. The first frame after init is unconditional.
- WIN: send 6 command bytes: 15 00 5F 75 00 3F. Then row=0, col=0, go to FETCH.
- FETCH: drive pix_addr={shown,row,col} for one cycle, then go to SEND.
- SEND: present pix_data as tx_byte with tx_dc=1.
  - On accept: advance col; when col reaches ROW_BYTES-1, wrap col to 0 and increment row.
  - After row ROWS-1, col ROW_BYTES-1: pulse frame_done and go to CHECK. Otherwise go to FETCH.
- CHECK:
  - If pending, or current≠shown: latch shown←current, clear pending, go to WIN.
  - Otherwise go to IDLE.
- IDLE: busy=0. Enter WIN (with shown←current) when current≠shown or force_refresh=1.
- pending is set by force_refresh in any state other than IDLE/CHECK. A current change during a frame needs no flag; CHECK compares. A frame in progress is never aborted; the next frame uses the value of current at CHECK.

## Timing
- Handshake: a byte transfers on a CLK edge where tx_valid&tx_ready=1.
  - tx_byte and tx_dc stay stable while tx_valid=1 and tx_ready=0.
  - tx_valid drops in the cycle after the final byte of each sequence.
- Command bytes: back-to-back. tx_valid stays high across consecutive commands when tx_ready is held 1, so there is 1 byte per cycle.
- Pixel bytes: at least 2 cycles per byte (FETCH + SEND). One frame takes at least 24576 cycles plus 6 window bytes.
- IDLE trigger sampled at edge N → tx_valid=1 with 8'h15 from edge N+1.
- force_refresh and a current change in the same cycle give exactly one frame.
- force_refresh in the cycle a frame ends (SEND final accept) is captured as pending and produces one more frame.
- RST asserted mid-frame returns all outputs to reset values asynchronously. The full RES/init sequence repeats on release.

## Test plan
- Power-up: RST released, RES_CYCLES=WAIT_CYCLES=4, tx_ready=1 → RES low for 4 cycles. First tx_byte=AE with tx_dc=0; 37 commands, then 15 00 5F 75 00 3F, then 12288 data bytes. frame_done pulses once; busy=0 after.
- Backpressure: tx_ready toggled randomly → no byte lost, duplicated or changed while stalled. Init byte sequence and ROM-addressed data match a reference model.
- Track change in IDLE: current 0→5 → window sent next cycle. pix_addr[16:14]=5 for all 12288 reads, in row-major order.
- Change mid-frame: current 1→2→3 during frame of 1 → frame 1 completes, then exactly one frame with shown=3.
- force_refresh with same current in IDLE → one frame with the unchanged image. Pulse coincident with a current change → one frame.
- Reset mid-frame at row 30: RES=0 and tx_valid=0 immediately. After release, init restarts from AE.

Source files
------------

// File: rtl/oled_frame_sched.sv
// OLED panel sequencer: panel reset timing, init command table, then a window-set
// block plus one full ROM frame whenever the shown track changes or a redraw is forced.
module oled_frame_sched #(
   parameter int RES_CYCLES  = 20000,
   parameter int WAIT_CYCLES = 20000,
   parameter int ROWS        = 64,
   parameter int ROW_BYTES   = 192
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [2:0]  current,
   input  logic        force_refresh,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_byte,
   output logic        tx_dc,
   output logic [16:0] pix_addr,
   input  logic [7:0]  pix_data,
   output logic        RES,
   output logic        busy,
   output logic        frame_done
);

   localparam int CNT_MAX = (RES_CYCLES > WAIT_CYCLES) ? RES_CYCLES : WAIT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RES_LAST  = CNT_W'(RES_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
   localparam logic [5:0] ROW_LAST  = 6'(ROWS - 1);
   localparam logic [7:0] COL_LAST  = 8'(ROW_BYTES - 1);
   localparam logic [5:0] INIT_LAST = 6'd36;
   localparam logic [5:0] WIN_LAST  = 6'd5;

   typedef enum logic [2:0] {
      RST_HOLD, RST_WAIT, INIT, WIN, FETCH, SEND, CHECK, IDLE
   } state_t;

   function automatic logic [7:0] init_byte(input logic [5:0] i);
      logic [7:0] b;
      case (i)
         6'd0:  b = 8'hAE;  6'd1:  b = 8'hA0;  6'd2:  b = 8'h76;  6'd3:  b = 8'hA1;
         6'd4:  b = 8'h00;  6'd5:  b = 8'hA2;  6'd6:  b = 8'h00;  6'd7:  b = 8'hA4;
         6'd8:  b = 8'hA8;  6'd9:  b = 8'h3F;  6'd10: b = 8'hAD;  6'd11: b = 8'h8E;
         6'd12: b = 8'hB0;  6'd13: b = 8'h0B;  6'd14: b = 8'hB1;  6'd15: b = 8'h31;
         6'd16: b = 8'hB3;  6'd17: b = 8'hF0;  6'd18: b = 8'h8A;  6'd19: b = 8'h64;
         6'd20: b = 8'h8B;  6'd21: b = 8'h78;  6'd22: b = 8'h8C;  6'd23: b = 8'h64;
         6'd24: b = 8'hBB;  6'd25: b = 8'h3A;  6'd26: b = 8'hBE;  6'd27: b = 8'h3E;
         6'd28: b = 8'h87;  6'd29: b = 8'h06;  6'd30: b = 8'h81;  6'd31: b = 8'h91;
         6'd32: b = 8'h82;  6'd33: b = 8'h50;  6'd34: b = 8'h83;  6'd35: b = 8'h7D;
         6'd36: b = 8'hAF;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   function automatic logic [7:0] win_byte(input logic [5:0] i);
      logic [7:0] b;
      case (i)
         6'd0: b = 8'h15;  6'd1: b = 8'h00;  6'd2: b = 8'h5F;
         6'd3: b = 8'h75;  6'd4: b = 8'h00;  6'd5: b = 8'h3F;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [5:0]        idx_q, idx_d;
   logic [5:0]        row_q, row_d;
   logic [7:0]        col_q, col_d;
   logic [2:0]        shown_q, shown_d;
   logic              pending_q, pending_d;
   logic              tx_valid_q, tx_valid_d;
   logic [7:0]        cmd_byte_q, cmd_byte_d;
   logic              tx_dc_q, tx_dc_d;
   logic [16:0]       pix_addr_q, pix_addr_d;
   logic              res_q, res_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
   logic              accept_s;

   assign accept_s = tx_valid_q & tx_ready;

   // Next-state and next-output computation for the sequencer.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      row_d        = row_q;
      col_d        = col_q;
      shown_d      = shown_q;
      tx_valid_d   = tx_valid_q;
      cmd_byte_d   = cmd_byte_q;
      tx_dc_d      = tx_dc_q;
      pix_addr_d   = pix_addr_q;
      res_d        = res_q;
      frame_done_d = 1'b0;
      if (force_refresh && (state_q != IDLE) && (state_q != CHECK)) begin
         pending_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end

      case (state_q)
         RST_HOLD: begin
            if (cnt_q == RES_LAST) begin
               cnt_d   = '0;
               res_d   = 1'b1;
               state_d = RST_WAIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RST_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               cnt_d   = '0;
               idx_d   = 6'd0;
               state_d = INIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         // Command sequences enter with tx_valid low and load their first byte here.
         INIT: begin
            if (!tx_valid_q) begin
               tx_valid_d = 1'b1;
               cmd_byte_d = init_byte(idx_q);
            end else if (accept_s) begin
               if (idx_q == INIT_LAST) begin
                  tx_valid_d = 1'b0;
                  idx_d      = 6'd0;
                  shown_d    = current;
                  pending_d  = 1'b0;
                  state_d    = WIN;
               end else begin
                  idx_d      = idx_q + 6'd1;
                  cmd_byte_d = init_byte(idx_q + 6'd1);
               end
            end else begin
               tx_valid_d = 1'b1;
            end
         end
         WIN: begin
            if (!tx_valid_q) begin
               tx_valid_d = 1'b1;
               cmd_byte_d = win_byte(idx_q);
            end else if (accept_s) begin
               if (idx_q == WIN_LAST) begin
                  tx_valid_d = 1'b0;
                  idx_d      = 6'd0;
                  row_d      = 6'd0;
                  col_d      = 8'd0;
                  pix_addr_d = {shown_q, 6'd0, 8'd0};
                  state_d    = FETCH;
               end else begin
                  idx_d      = idx_q + 6'd1;
                  cmd_byte_d = win_byte(idx_q + 6'd1);
               end
            end else begin
               tx_valid_d = 1'b1;
            end
         end
         FETCH: begin
            tx_valid_d = 1'b1;
            tx_dc_d    = 1'b1;
            state_d    = SEND;
         end
         SEND: begin
            if (accept_s) begin
               tx_valid_d = 1'b0;
               tx_dc_d    = 1'b0;
               if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
                  frame_done_d = 1'b1;
                  state_d      = CHECK;
               end else begin
                  if (col_q == COL_LAST) begin
                     col_d = 8'd0;
                     row_d = row_q + 6'd1;
                  end else begin
                     col_d = col_q + 8'd1;
                  end
                  pix_addr_d = {shown_q, row_d, col_d};
                  state_d    = FETCH;
               end
            end else begin
               tx_valid_d = 1'b1;
            end
         end
         CHECK: begin
            if (pending_q || (current != shown_q)) begin
               shown_d   = current;
               pending_d = 1'b0;
               state_d   = WIN;
            end else begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if ((current != shown_q) || force_refresh) begin
               shown_d = current;
               state_d = WIN;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = RST_HOLD;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= RST_HOLD;
         cnt_q        <= '0;
         idx_q        <= 6'd0;
         row_q        <= 6'd0;
         col_q        <= 8'd0;
         shown_q      <= 3'd0;
         pending_q    <= 1'b0;
         tx_valid_q   <= 1'b0;
         cmd_byte_q   <= 8'h00;
         tx_dc_q      <= 1'b0;
         pix_addr_q   <= 17'd0;
         res_q        <= 1'b0;
         busy_q       <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         row_q        <= row_d;
         col_q        <= col_d;
         shown_q      <= shown_d;
         pending_q    <= pending_d;
         tx_valid_q   <= tx_valid_d;
         cmd_byte_q   <= cmd_byte_d;
         tx_dc_q      <= tx_dc_d;
         pix_addr_q   <= pix_addr_d;
         res_q        <= res_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Pixel bytes come straight off the ROM port; pix_addr is held through SEND,
   // so the byte stays stable while the serializer stalls.
   assign tx_byte    = tx_dc_q ? pix_data : cmd_byte_q;
   assign tx_valid   = tx_valid_q;
   assign tx_dc      = tx_dc_q;
   assign pix_addr   = pix_addr_q;
   assign RES        = res_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;

endmodule
